// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue between dispatch, CDB writeback and the register file.
// Ports: clk/rst (sync, active-high); alloc_*_from_dsp / alloc_id_to_dsp / full_to_dsp allocate tags;
//   cdb_* marks an entry ready with its result; commit_*_to_rf retires one entry per cycle (registered);
//   commit_jump_flag_to_rf / flush_pc_to_if redirect fetch on a mispredicted branch.
// Optional: define ROB_COMMIT_TRACE_EN for a simulation-only commit counter and per-commit trace print.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_en_from_dsp,
  input  logic [4:0]      alloc_rd_from_dsp,
  input  logic            alloc_is_br_from_dsp,
  input  logic            alloc_pred_taken_from_dsp,
  output logic [ID_W-1:0] alloc_id_to_dsp,
  output logic            full_to_dsp,
  input  logic            cdb_en,
  input  logic [ID_W-1:0] cdb_id,
  input  logic [31:0]     cdb_value,
  input  logic            cdb_taken,
  input  logic [31:0]     cdb_target_pc,
  output logic            commit_flag_to_rf,
  output logic [4:0]      commit_rd_to_rf,
  output logic [ID_W-1:0] commit_Q_to_rf,
  output logic [31:0]     commit_V_to_rf,
  output logic            commit_jump_flag_to_rf,
  output logic [31:0]     flush_pc_to_if
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic        is_br;
    logic        pred_taken;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target_pc;
  } entry_t;

  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  entry_t              ent_q [ROB_SIZE];
  entry_t              ent_d [ROB_SIZE];
  logic [IDX_W-1:0]    head_q, head_d;
  logic [IDX_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                cflag_q, cflag_d;
  logic [4:0]          crd_q, crd_d;
  logic [ID_W-1:0]     cq_q, cq_d;
  logic [31:0]         cv_q, cv_d;
  logic                jump_q, jump_d;
  logic [31:0]         flush_pc_q, flush_pc_d;

  logic                full;
  logic                alloc_fire;
  logic                cdb_in_range;
  logic [IDX_W-1:0]    cdb_slot;
  logic                cdb_fire;
  entry_t              head_ent;
  logic                commit_fire;
  logic                mispredict;

  // Everything the dispatcher sees comes from registered state only.
  assign full            = (count_q == CNT_W'(ROB_SIZE));
  assign full_to_dsp     = full;
  assign alloc_id_to_dsp = ID_W'(tail_q) + ID_W'(1);

  assign alloc_fire   = alloc_en_from_dsp && !full;
  // Tag 0 means "no producer"; tags beyond the buffer cannot name an entry.
  assign cdb_in_range = (cdb_id != '0) && (cdb_id <= ID_W'(ROB_SIZE));
  assign cdb_slot     = IDX_W'(cdb_id - ID_W'(1));
  assign cdb_fire     = cdb_en && cdb_in_range && busy_q[cdb_slot];

  assign head_ent    = ent_q[head_q];
  assign commit_fire = busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && head_ent.is_br && (head_ent.taken != head_ent.pred_taken);

  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cflag_d    = 1'b0;
    crd_d      = '0;
    cq_d       = '0;
    cv_d       = '0;
    jump_d     = 1'b0;
    flush_pc_d = '0;

    if (alloc_fire) begin
      busy_d[tail_q]           = 1'b1;
      ready_d[tail_q]          = 1'b0;
      ent_d[tail_q].rd         = alloc_rd_from_dsp;
      ent_d[tail_q].is_br      = alloc_is_br_from_dsp;
      ent_d[tail_q].pred_taken = alloc_pred_taken_from_dsp;
      tail_d                   = tail_q + IDX_W'(1);
    end

    if (cdb_fire) begin
      ent_d[cdb_slot].value     = cdb_value;
      ent_d[cdb_slot].taken     = cdb_taken;
      ent_d[cdb_slot].target_pc = cdb_target_pc;
      ready_d[cdb_slot]         = 1'b1;
    end

    if (commit_fire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
      cflag_d         = (head_ent.rd != 5'd0);
      crd_d           = head_ent.rd;
      cq_d            = ID_W'(head_q) + ID_W'(1);
      cv_d            = head_ent.value;
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A mispredict wipes every younger entry, including anything allocated
    // or written back on the same edge; the link-register write still retires.
    if (mispredict) begin
      jump_d     = 1'b1;
      flush_pc_d = head_ent.target_pc;
      busy_d     = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      ready_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cflag_q    <= 1'b0;
      crd_q      <= '0;
      cq_q       <= '0;
      cv_q       <= '0;
      jump_q     <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cflag_q    <= cflag_d;
      crd_q      <= crd_d;
      cq_q       <= cq_d;
      cv_q       <= cv_d;
      jump_q     <= jump_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign commit_flag_to_rf      = cflag_q;
  assign commit_rd_to_rf        = crd_q;
  assign commit_Q_to_rf         = cq_q;
  assign commit_V_to_rf         = cv_q;
  assign commit_jump_flag_to_rf = jump_q;
  assign flush_pc_to_if         = flush_pc_q;

`ifdef ROB_COMMIT_TRACE_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (commit_fire) commit_cnt_d = commit_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_q <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      if (commit_fire)
        $display("rob commit #%0d tag=%0d rd=%0d value=0x%08h flush=%0b",
                 commit_cnt_d, ID_W'(head_q) + ID_W'(1), head_ent.rd, head_ent.value, mispredict);
    end
  end
`else
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_en_from_dsp = 1'b0;
  logic [4:0]      alloc_rd_from_dsp = '0;
  logic            alloc_is_br_from_dsp = 1'b0;
  logic            alloc_pred_taken_from_dsp = 1'b0;
  logic [ID_W-1:0] alloc_id_to_dsp;
  logic            full_to_dsp;
  logic            cdb_en = 1'b0;
  logic [ID_W-1:0] cdb_id = '0;
  logic [31:0]     cdb_value = '0;
  logic            cdb_taken = 1'b0;
  logic [31:0]     cdb_target_pc = '0;
  logic            commit_flag_to_rf;
  logic [4:0]      commit_rd_to_rf;
  logic [ID_W-1:0] commit_Q_to_rf;
  logic [31:0]     commit_V_to_rf;
  logic            commit_jump_flag_to_rf;
  logic [31:0]     flush_pc_to_if;

  reorder_buffer #(.ROB_SIZE(ROB_SIZE), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_en_from_dsp(alloc_en_from_dsp), .alloc_rd_from_dsp(alloc_rd_from_dsp),
    .alloc_is_br_from_dsp(alloc_is_br_from_dsp), .alloc_pred_taken_from_dsp(alloc_pred_taken_from_dsp),
    .alloc_id_to_dsp(alloc_id_to_dsp), .full_to_dsp(full_to_dsp),
    .cdb_en(cdb_en), .cdb_id(cdb_id), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .cdb_target_pc(cdb_target_pc),
    .commit_flag_to_rf(commit_flag_to_rf), .commit_rd_to_rf(commit_rd_to_rf),
    .commit_Q_to_rf(commit_Q_to_rf), .commit_V_to_rf(commit_V_to_rf),
    .commit_jump_flag_to_rf(commit_jump_flag_to_rf), .flush_pc_to_if(flush_pc_to_if)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;   // edge count at which the pulse must be seen, -1 = any
    logic        flag;
    logic [4:0]  rd;
    logic [4:0]  q;
    logic [31:0] v;
    logic        jump;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic push_exp(input int cyc, input logic flag, input logic [4:0] rd, input logic [4:0] q,
                          input logic [31:0] v, input logic jump, input logic [31:0] pc);
    exp_t e;
    e.cyc = cyc; e.flag = flag; e.rd = rd; e.q = q; e.v = v; e.jump = jump; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit or flush pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (commit_flag_to_rf || commit_jump_flag_to_rf) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got flag=%0b Q=%0d jump=%0b, expected no pulse (t=%0t)",
                 commit_flag_to_rf, commit_Q_to_rf, commit_jump_flag_to_rf, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc >= 0) chk("commit_cycle", edge_cnt, mon_e.cyc);
        chk("commit_flag", {31'd0, commit_flag_to_rf}, {31'd0, mon_e.flag});
        chk("commit_jump", {31'd0, commit_jump_flag_to_rf}, {31'd0, mon_e.jump});
        if (mon_e.flag) begin
          chk("commit_rd", {27'd0, commit_rd_to_rf}, {27'd0, mon_e.rd});
          chk("commit_Q", {27'd0, commit_Q_to_rf}, {27'd0, mon_e.q});
          chk("commit_V", commit_V_to_rf, mon_e.v);
        end
        if (mon_e.jump) chk("flush_pc", flush_pc_to_if, mon_e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_en_from_dsp = 1'b0;
    cdb_en = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic is_br, input logic pred);
    alloc_en_from_dsp = 1'b1;
    alloc_rd_from_dsp = rd;
    alloc_is_br_from_dsp = is_br;
    alloc_pred_taken_from_dsp = pred;
    tick();
    alloc_en_from_dsp = 1'b0;
  endtask

  // Returns the edge index at which the writeback was captured.
  task automatic cdb(input logic [4:0] id, input logic [31:0] val, input logic taken,
                     input logic [31:0] tgt, output int n);
    cdb_en = 1'b1;
    cdb_id = id;
    cdb_value = val;
    cdb_taken = taken;
    cdb_target_pc = tgt;
    tick();
    n = edge_cnt;
    cdb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    idle(2);
    chk("rst_full", {31'd0, full_to_dsp}, 32'd0);
    chk("rst_alloc_id", {27'd0, alloc_id_to_dsp}, 32'd1);
    chk("rst_commit_flag", {31'd0, commit_flag_to_rf}, 32'd0);
    chk("rst_jump", {31'd0, commit_jump_flag_to_rf}, 32'd0);
    chk("rst_flush_pc", flush_pc_to_if, 32'd0);
    chk("rst_commit_V", commit_V_to_rf, 32'd0);
    rst = 1'b0;

    // Basic alloc -> writeback -> commit two cycles later
    alloc(5'd5, 1'b0, 1'b0);
    chk("alloc_id_after_one", {27'd0, alloc_id_to_dsp}, 32'd2);
    cdb(5'd1, 32'h12345678, 1'b0, 32'd0, n);
    push_exp(n + 1, 1'b1, 5'd5, 5'd1, 32'h12345678, 1'b0, 32'd0);
    idle(4);

    // Out-of-order writeback, in-order commit on consecutive cycles
    do_reset();
    alloc(5'd10, 1'b0, 1'b0);
    alloc(5'd11, 1'b0, 1'b0);
    alloc(5'd12, 1'b0, 1'b0);
    cdb(5'd3, 32'h33, 1'b0, 32'd0, n);
    cdb(5'd2, 32'h22, 1'b0, 32'd0, n);
    cdb(5'd1, 32'h11, 1'b0, 32'd0, n);
    push_exp(n + 1, 1'b1, 5'd10, 5'd1, 32'h11, 1'b0, 32'd0);
    push_exp(n + 2, 1'b1, 5'd11, 5'd2, 32'h22, 1'b0, 32'd0);
    push_exp(n + 3, 1'b1, 5'd12, 5'd3, 32'h33, 1'b0, 32'd0);
    idle(5);

    // Fill, ignored 17th alloc, commit frees a slot but same-cycle alloc is ignored
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++) alloc(5'(i + 1), 1'b0, 1'b0);
    chk("full_at_16", {31'd0, full_to_dsp}, 32'd1);
    chk("alloc_id_full_wrap", {27'd0, alloc_id_to_dsp}, 32'd1);
    alloc(5'd31, 1'b0, 1'b0);
    chk("full_after_17th", {31'd0, full_to_dsp}, 32'd1);
    chk("alloc_id_after_17th", {27'd0, alloc_id_to_dsp}, 32'd1);
    cdb(5'd1, 32'hAAAA0001, 1'b0, 32'd0, n);
    push_exp(n + 1, 1'b1, 5'd1, 5'd1, 32'hAAAA0001, 1'b0, 32'd0);
    alloc(5'd30, 1'b0, 1'b0);   // lands on the commit edge while still full
    chk("full_after_commit", {31'd0, full_to_dsp}, 32'd0);
    chk("alloc_id_after_commit", {27'd0, alloc_id_to_dsp}, 32'd1);
    alloc(5'd29, 1'b0, 1'b0);
    chk("refull", {31'd0, full_to_dsp}, 32'd1);
    chk("alloc_id_refill", {27'd0, alloc_id_to_dsp}, 32'd2);

    // Mispredicted branch with 4 ready younger entries
    do_reset();
    alloc(5'd1, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) alloc(5'(i), 1'b0, 1'b0);
    for (int i = 2; i <= 5; i++) cdb(5'(i), 32'hB0 + 32'(i), 1'b0, 32'd0, n);
    cdb(5'd1, 32'h44, 1'b1, 32'h1000, n);
    push_exp(n + 1, 1'b1, 5'd1, 5'd1, 32'h44, 1'b1, 32'h1000);
    cdb_en = 1'b1; cdb_id = 5'd3; cdb_value = 32'hDEAD;
    alloc(5'd6, 1'b0, 1'b0);    // same edge as the flush: discarded
    cdb_en = 1'b0;
    chk("flush_alloc_id", {27'd0, alloc_id_to_dsp}, 32'd1);
    chk("flush_full", {31'd0, full_to_dsp}, 32'd0);
    idle(6);
    for (int i = 0; i < ROB_SIZE - 1; i++) alloc(5'd0, 1'b0, 1'b0);
    chk("flush_count_15", {31'd0, full_to_dsp}, 32'd0);
    alloc(5'd0, 1'b0, 1'b0);
    chk("flush_count_16", {31'd0, full_to_dsp}, 32'd1);

    // rd=0 entry, correctly predicted branches, rd=0 mispredict
    do_reset();
    alloc(5'd0, 1'b0, 1'b0);
    alloc(5'd7, 1'b1, 1'b1);
    alloc(5'd9, 1'b1, 1'b0);
    alloc(5'd0, 1'b1, 1'b1);
    push_exp(-1, 1'b1, 5'd7, 5'd2, 32'h77, 1'b0, 32'd0);
    push_exp(-1, 1'b1, 5'd9, 5'd3, 32'h99, 1'b0, 32'd0);
    push_exp(-1, 1'b0, 5'd0, 5'd4, 32'h0, 1'b1, 32'h2000);
    cdb(5'd1, 32'h11, 1'b0, 32'd0, n);
    cdb(5'd2, 32'h77, 1'b1, 32'h500, n);
    cdb(5'd3, 32'h99, 1'b0, 32'h600, n);
    cdb(5'd4, 32'h0, 1'b0, 32'h2000, n);
    idle(6);
    chk("rd0_flush_alloc_id", {27'd0, alloc_id_to_dsp}, 32'd1);

    // Reset with three ready entries: no commit pulse
    do_reset();
    alloc(5'd1, 1'b0, 1'b0);
    alloc(5'd2, 1'b0, 1'b0);
    alloc(5'd3, 1'b0, 1'b0);
    cdb(5'd3, 32'h3, 1'b0, 32'd0, n);
    cdb(5'd2, 32'h2, 1'b0, 32'd0, n);
    cdb(5'd1, 32'h1, 1'b0, 32'd0, n);
    do_reset();
    chk("post_rst_full", {31'd0, full_to_dsp}, 32'd0);
    chk("post_rst_alloc_id", {27'd0, alloc_id_to_dsp}, 32'd1);
    chk("post_rst_flag", {31'd0, commit_flag_to_rf}, 32'd0);
    alloc(5'd4, 1'b0, 1'b0);
    cdb(5'd1, 32'h55, 1'b0, 32'd0, n);
    push_exp(n + 1, 1'b1, 5'd4, 5'd1, 32'h55, 1'b0, 32'd0);
    idle(4);

    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
